enc_seq_ctrl: RTL and testbench
===============================

Name: enc_seq_ctrl

Overview:
Sequencer for one hyperdimensional sample encoder datapath. Accepts a start command with a per-sample feature count. Streams exactly that many bound feature hypervectors into the encoder, then waits for the encoder's completion flag. Captures the thresholded sample hypervector and presents it on a valid/ready output; sits between the bind stage and the class-memory/training logic.

Parameters:
CNT_W, 8, width of feature-count config and internal feature counter; must match the encoder's CNT_W
DONE_WAIT, 4, max cycles to wait for enc_done after last feature before flagging error (range 1..255)
Vector width is the global `DIM from define.sv, not a parameter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin sample; sampled only in IDLE
cfg_cnt  in  CNT_W  features in this sample; latched on accepted start
busy  out  1  high in any state except IDLE
feat_valid  in  1  upstream feature valid
feat_ready  out  1  high only in ACCUM
feat_data  in  `DIM  bound feature hypervector
enc_en  out  1  encoder accumulate enable = feat_valid & feat_ready
enc_clear  out  1  encoder accumulator clear, one cycle in CLEAR
enc_cnt  out  CNT_W  latched count to encoder, stable from CLEAR through CAPT
enc_data  out  `DIM  pass-through of feat_data
enc_done  in  1  encoder completion
enc_result  in  `DIM  encoder output register
hv_valid  out  1  sample hypervector valid
hv_ready  in  1  downstream ready
hv_data  out  `DIM  captured sample hypervector
err  out  1  one-cycle error pulse

Behaviour:
- One clock; reset is asynchronous and active-high. While rst is high, state = IDLE, cnt_q = 0, feat counter = 0, hv_data = 0. All outputs are 0: busy, feat_ready, enc_en, enc_clear, enc_cnt, hv_valid, hv_data, err.
- Reset asserted mid-sample aborts immediately; no partial output.
- States: IDLE, CLEAR, ACCUM, WAIT, CAPT, OUT.
- IDLE: on start & cfg_cnt != 0, latch cnt_q = cfg_cnt and go to CLEAR.
  - start & cfg_cnt == 0: stay IDLE, err = 1 for one cycle.
- CLEAR: enc_clear = 1 for exactly one cycle, feat counter = 0, then go to ACCUM.
- ACCUM: feat_ready = 1. Each cycle with feat_valid = 1 is one accepted feature; counter increments by 1.
  - Counter width is CNT_W, with no wrap because count < cnt_q.
  - When the accepted feature is number cnt_q (counter == cnt_q-1 at accept), go to WAIT.
  - feat_valid low: hold state, enc_en = 0 (bubbles allowed, unlimited in ACCUM).
- WAIT: feat_ready = 0. On enc_done = 1 go to CAPT.
  - enc_done may arrive in the same cycle as the last accept; then ACCUM goes directly to CAPT.
  - If DONE_WAIT cycles elapse without enc_done: err = 1 for one cycle, go to IDLE, no output.
- CAPT: one-cycle delay for the encoder's output register to load. At the end of this cycle hv_data <= enc_result; go to OUT.
- OUT: hv_valid = 1. hv_data is held stable until hv_valid & hv_ready, then go to IDLE.
  - hv_valid never drops without a handshake.
  - start during OUT is ignored (not queued).
- Latency: start to first feat_ready = 2 cycles. Last feature accept to hv_valid = 2 cycles, if enc_done arrives on the accept cycle.
- enc_done outside WAIT/ACCUM is ignored.
- busy = (state != IDLE).

Optional Feature:
ENC_SEQ_PERF_EN:
- Defined: adds outputs perf_samples (32 bits) and perf_stall (32 bits), both reset to 0.
  - perf_samples increments on each hv handshake.
  - perf_stall increments each ACCUM cycle with feat_valid = 0 and each OUT cycle with hv_ready = 0.
  - Both saturate at 2^32-1.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then start with cfg_cnt = 5 and feat_valid held high; enc_done pulses on the 5th accept. Expect: enc_clear pulses 1 cycle; exactly 5 enc_en cycles; hv_valid 2 cycles after the last accept; hv_data equals enc_result sampled in CAPT.
- cfg_cnt = 3 with feat_valid toggled 1,0,0,1,0,1. Expect: exactly 3 accepts; counter ignores bubbles; WAIT entered after the 3rd accept.
- In OUT, hold hv_ready = 0 for 10 cycles. Expect: hv_valid stays 1 and hv_data stays stable; start pulses are ignored. Release hv_ready: handshake, then IDLE next cycle.
- start with cfg_cnt = 0. Expect: err pulse of 1 cycle, busy stays 0, no enc_clear.
- cfg_cnt = 4, enc_done withheld, DONE_WAIT = 4. Expect: err pulse 4 cycles after entering WAIT, return to IDLE, hv_valid never asserts.
- Assert rst for 1 cycle mid-ACCUM after 2 of 6 features. Expect: all outputs 0 immediately. A fresh start with cfg_cnt = 2 then completes normally with exactly 2 enc_en cycles.

Source files
------------

// File: rtl/enc_seq_ctrl_if.sv
// Handshake bundle for the HD sample-encoder sequencer.
// Optional perf counters appear when ENC_SEQ_PERF_EN is defined.
`ifndef DIM
`define DIM 64
`endif

interface enc_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] cfg_cnt;
  logic             busy;
  logic             feat_valid;
  logic             feat_ready;
  logic [`DIM-1:0]  feat_data;
  logic             enc_en;
  logic             enc_clear;
  logic [CNT_W-1:0] enc_cnt;
  logic [`DIM-1:0]  enc_data;
  logic             enc_done;
  logic [`DIM-1:0]  enc_result;
  logic             hv_valid;
  logic             hv_ready;
  logic [`DIM-1:0]  hv_data;
  logic             err;
`ifdef ENC_SEQ_PERF_EN
  logic [31:0]      perf_samples;
  logic [31:0]      perf_stall;
`endif

  modport slave (
    input  start, cfg_cnt, feat_valid, feat_data,
    input  enc_done, enc_result, hv_ready,
    output busy, feat_ready, enc_en, enc_clear,
    output enc_cnt, enc_data, hv_valid, hv_data, err
`ifdef ENC_SEQ_PERF_EN
    , output perf_samples, perf_stall
`endif
  );

  modport master (
    output start, cfg_cnt, feat_valid, feat_data,
    output enc_done, enc_result, hv_ready,
    input  busy, feat_ready, enc_en, enc_clear,
    input  enc_cnt, enc_data, hv_valid, hv_data, err
`ifdef ENC_SEQ_PERF_EN
    , input perf_samples, perf_stall
`endif
  );
endinterface

// File: rtl/enc_seq_ctrl.sv
// Sequencer for one HD sample encoder: clear, stream features, capture.
// Define ENC_SEQ_PERF_EN to add sample/stall performance counters.
`ifndef DIM
`define DIM 64
`endif

module enc_seq_ctrl #(
  parameter int CNT_W     = 8,
  parameter int DONE_WAIT = 4
) (
  input logic           clk,
  input logic           rst,
  enc_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_WAIT, S_CAPT, S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [`DIM-1:0]  hv_q, hv_d;
  logic             err_q, err_d;
  logic             last;
  logic             timeout;

  assign last    = fcnt_q == (cnt_q - CNT_W'(1));
  assign timeout = ~bus.enc_done &
                   (wcnt_q == 8'(DONE_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      wcnt_q  <= '0;
      hv_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      wcnt_q  <= wcnt_d;
      hv_q    <= hv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    wcnt_d  = '0;
    hv_d    = hv_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.cfg_cnt != '0) begin
            cnt_d   = bus.cfg_cnt;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        fcnt_d  = '0;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (bus.feat_valid) begin
          fcnt_d = fcnt_q + CNT_W'(1);
          if (last)
            state_d = bus.enc_done ? S_CAPT : S_WAIT;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        if (bus.enc_done) begin
          state_d = S_CAPT;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_CAPT: begin
        hv_d    = bus.enc_result;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.hv_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = state_q != S_IDLE;
    bus.feat_ready = state_q == S_ACCUM;
    bus.enc_en     = bus.feat_valid & (state_q == S_ACCUM);
    bus.enc_clear  = state_q == S_CLEAR;
    bus.enc_cnt    = cnt_q;
    bus.enc_data   = bus.feat_data;
    bus.hv_valid   = state_q == S_OUT;
    bus.hv_data    = hv_q;
    bus.err        = err_q;
  end

`ifdef ENC_SEQ_PERF_EN
  logic [31:0] psmp_q, pstl_q;
  logic        smp_inc, stl_inc;

  assign smp_inc = (state_q == S_OUT) & bus.hv_ready;
  assign stl_inc = ((state_q == S_ACCUM) & ~bus.feat_valid) |
                   ((state_q == S_OUT) & ~bus.hv_ready);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psmp_q <= '0;
      pstl_q <= '0;
    end else begin
      if (smp_inc && !(&psmp_q)) psmp_q <= psmp_q + 32'd1;
      if (stl_inc && !(&pstl_q)) pstl_q <= pstl_q + 32'd1;
    end
  end

  assign bus.perf_samples = psmp_q;
  assign bus.perf_stall   = pstl_q;
`endif

endmodule

// File: tb/tb_enc_seq_ctrl.sv
// Self-checking bench for enc_seq_ctrl: directed scenarios plus
// randomized samples checked against a sample-level reference model.
`ifndef DIM
`define DIM 64
`endif

module tb_enc_seq_ctrl;
  localparam int CNT_W     = 8;
  localparam int DONE_WAIT = 4;
  localparam int DIM       = `DIM;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [DIM-1:0] sb[$];
`ifdef ENC_SEQ_PERF_EN
  int exp_samples = 0;
  int exp_stall   = 0;
`endif

  enc_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  enc_seq_ctrl #(
    .CNT_W(CNT_W),
    .DONE_WAIT(DONE_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [DIM-1:0] obs,
                      input logic [DIM-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DIM-1:0] rnd();
    logic [DIM-1:0] v = '0;
    for (int i = 0; i < (DIM + 31) / 32; i++)
      v = (v << 32) ^ DIM'($urandom);
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chkb({tag, "_busy"}, bus.busy, 1'b0);
    chkb({tag, "_rdy"}, bus.feat_ready, 1'b0);
    chkb({tag, "_en"}, bus.enc_en, 1'b0);
    chkb({tag, "_clr"}, bus.enc_clear, 1'b0);
    chki({tag, "_cnt"}, int'(bus.enc_cnt), 0);
    chkb({tag, "_hvv"}, bus.hv_valid, 1'b0);
    chkv({tag, "_hvd"}, bus.hv_data, '0);
    chkb({tag, "_err"}, bus.err, 1'b0);
  endtask

  // One full sample. dwait < 0: enc_done on the last accept;
  // otherwise dwait idle WAIT cycles precede enc_done.
  task automatic do_sample(input int n, input int vpct,
                           input logic [15:0] pat, input bit use_pat,
                           input int dwait, input int rwait);
    int acc = 0;
    int en_seen = 0;
    int cyc = 0;
    logic fv;
    logic [DIM-1:0] exp;
    bus.start   = 1'b1;
    bus.cfg_cnt = CNT_W'(n);
    #1 chkb("idle_busy", bus.busy, 1'b0);
    tick();
    bus.start = 1'b0;
    #1;
    chkb("clear_pulse", bus.enc_clear, 1'b1);
    chkb("clear_rdy", bus.feat_ready, 1'b0);
    chki("enc_cnt", int'(bus.enc_cnt), n);
    tick();
    while (acc < n && cyc < 300) begin
      if (use_pat && cyc < 16) fv = pat[cyc];
      else fv = int'($urandom_range(99)) < vpct;
      bus.feat_valid = fv;
      bus.feat_data  = rnd();
      bus.enc_result = rnd();
      bus.enc_done   = (dwait < 0) && fv && (acc == n - 1);
      #1;
      chkb("accum_rdy", bus.feat_ready, 1'b1);
      chkb("clear_once", bus.enc_clear, 1'b0);
      chkb("enc_en", bus.enc_en, fv);
      chkv("enc_data", bus.enc_data, bus.feat_data);
      chki("enc_cnt_hold", int'(bus.enc_cnt), n);
      en_seen += int'(bus.enc_en);
      if (fv) acc++;
`ifdef ENC_SEQ_PERF_EN
      else exp_stall++;
`endif
      cyc++;
      tick();
    end
    chkb("accum_bound", cyc < 300, 1'b1);
    bus.feat_valid = 1'b0;
    bus.enc_done   = 1'b0;
    if (dwait >= 0) begin
      for (int i = 0; i < dwait; i++) begin
        #1;
        chkb("wait_rdy", bus.feat_ready, 1'b0);
        chkb("wait_busy", bus.busy, 1'b1);
        chkb("wait_hv", bus.hv_valid, 1'b0);
        tick();
      end
      bus.enc_done = 1'b1;
      #1 chkb("wait_rdy_done", bus.feat_ready, 1'b0);
      tick();
      bus.enc_done = 1'b0;
    end
    exp = rnd();
    bus.enc_result = exp;
    sb.push_back(exp);
    #1;
    chkb("capt_hv", bus.hv_valid, 1'b0);
    chkb("capt_busy", bus.busy, 1'b1);
    tick();
    bus.enc_result = rnd();
    for (int i = 0; i < rwait; i++) begin
      bus.hv_ready = 1'b0;
      bus.start    = $urandom_range(1) == 1;
      bus.cfg_cnt  = CNT_W'(3);
      #1;
      chkb("out_valid", bus.hv_valid, 1'b1);
      chkv("out_hold", bus.hv_data, exp);
      chkb("out_rdy", bus.feat_ready, 1'b0);
`ifdef ENC_SEQ_PERF_EN
      exp_stall++;
`endif
      tick();
    end
    bus.start    = 1'b0;
    bus.hv_ready = 1'b1;
    #1;
    chkb("hs_valid", bus.hv_valid, 1'b1);
    if (sb.size() > 0) chkv("sb_data", bus.hv_data, sb.pop_front());
`ifdef ENC_SEQ_PERF_EN
    exp_samples++;
`endif
    tick();
    bus.hv_ready = 1'b0;
    #1;
    chkb("post_busy", bus.busy, 1'b0);
    chkb("post_hv", bus.hv_valid, 1'b0);
    chkb("post_clear", bus.enc_clear, 1'b0);
    chki("en_count", en_seen, n);
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.cfg_cnt    = '0;
    bus.feat_valid = 1'b0;
    bus.feat_data  = '0;
    bus.enc_done   = 1'b0;
    bus.enc_result = '0;
    bus.hv_ready   = 1'b0;
    tick();
    tick();
    #1 chk_zero("rst");
    rst = 1'b0;
    tick();

    // Full-rate stream, done on last accept
    do_sample(5, 100, 16'h0, 1'b0, -1, 0);
    // Bubbles 1,0,0,1,0,1 then one WAIT cycle
    do_sample(3, 0, 16'b0000_0000_0010_1001, 1'b1, 1, 2);
    // Long back-pressure in OUT, start pulses ignored
    do_sample(3, 100, 16'h0, 1'b0, 0, 10);

    // Zero count
    bus.start   = 1'b1;
    bus.cfg_cnt = '0;
    #1;
    chkb("zc_busy0", bus.busy, 1'b0);
    chkb("zc_err0", bus.err, 1'b0);
    tick();
    bus.start = 1'b0;
    #1;
    chkb("zc_err", bus.err, 1'b1);
    chkb("zc_busy", bus.busy, 1'b0);
    chkb("zc_clear", bus.enc_clear, 1'b0);
    tick();
    #1 chkb("zc_err_end", bus.err, 1'b0);
    tick();

    // Done withheld -> timeout
    bus.start   = 1'b1;
    bus.cfg_cnt = CNT_W'(4);
    tick();
    bus.start = 1'b0;
    tick();
    bus.feat_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.feat_valid = 1'b0;
    for (int i = 0; i < DONE_WAIT; i++) begin
      #1;
      chkb("to_err_low", bus.err, 1'b0);
      chkb("to_busy", bus.busy, 1'b1);
      chkb("to_hv", bus.hv_valid, 1'b0);
      tick();
    end
    #1;
    chkb("to_err", bus.err, 1'b1);
    chkb("to_idle", bus.busy, 1'b0);
    chkb("to_hv_none", bus.hv_valid, 1'b0);
    tick();
    #1;
    chkb("to_err_end", bus.err, 1'b0);
    chkb("to_hv_after", bus.hv_valid, 1'b0);
    tick();

    // Reset mid-ACCUM after 2 of 6 features
    bus.start   = 1'b1;
    bus.cfg_cnt = CNT_W'(6);
    tick();
    bus.start = 1'b0;
    tick();
    bus.feat_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1 chk_zero("mid_rst");
    tick();
    rst            = 1'b0;
    bus.feat_valid = 1'b0;
`ifdef ENC_SEQ_PERF_EN
    exp_samples = 0;
    exp_stall   = 0;
`endif
    tick();
    do_sample(2, 100, 16'h0, 1'b0, -1, 1);

    // Randomized samples
    for (int k = 0; k < 8; k++)
      do_sample(int'($urandom_range(12, 1)), int'($urandom_range(100, 30)),
                16'h0, 1'b0, int'($urandom_range(DONE_WAIT, 0)) - 1,
                int'($urandom_range(5, 0)));

`ifdef ENC_SEQ_PERF_EN
    chki("perf_samples", int'(bus.perf_samples), exp_samples);
    chki("perf_stall", int'(bus.perf_stall), exp_stall);
`endif
    chki("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
